uart_cmd_sequencer: RTL and testbench

//   Controller that sits between the UART receiver and the command consumer.
//   It drains received bytes (rx_rdy/rx_data, clearing rx_rdy via clr_rx_rdy),

---
 rtl/uart_cmd_sequencer.sv | 91 +++++++++
 tb/tb_uart_cmd_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Drains UART receiver bytes into CMD_BYTES-wide command words (MSB first) with a
// cmd_rdy/clr_cmd_rdy handshake, receiver back-pressure while holding, and an inter-byte timeout.
module uart_cmd_sequencer #(
  parameter int unsigned CMD_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*CMD_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int unsigned CW      = 8 * CMD_BYTES;
  localparam int unsigned BW      = $clog2(CMD_BYTES + 1);
  localparam int unsigned TW      = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic [TW-1:0] to_cnt;
  logic          accept;
  logic          last_byte;
  logic          to_hit;

  // Mealy accept so each pending byte is consumed on exactly one edge.
  assign accept     = rx_rdy && (state != HOLD) && !rst;
  assign clr_rx_rdy = accept;
  assign busy       = (state == COLLECT) && !rst;
  assign last_byte  = (byte_cnt == BW'(CMD_BYTES - 1));
  assign to_hit     = TO_EN && (state == COLLECT) && !accept && (to_cnt == TW'(TO_LAST));

  // Single-process FSM: an accept always wins over timeout in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
      timeout_err <= 1'b0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (accept) begin
        cmd      <= CW'({cmd, rx_data});
        byte_cnt <= byte_cnt + 1'b1;
        to_cnt   <= '0;
        if (last_byte) begin
          state   <= HOLD;
          cmd_rdy <= 1'b1;
        end else begin
          state <= COLLECT;
        end
      end else begin
        case (state)
          COLLECT: begin
            if (to_hit) begin
              state       <= IDLE;
              byte_cnt    <= '0;
              to_cnt      <= '0;
              timeout_err <= 1'b1;
            end else if (to_cnt != '1) begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (clr_cmd_rdy) begin
              state    <= IDLE;
              cmd_rdy  <= 1'b0;
              byte_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: three instances (2B/no practical timeout,
// 2B/timeout 50, 1B/timeout 50) with a scoreboard queue of expected command words.
module tb_uart_cmd_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  rx_rdy;
  logic [7:0]  rx_data [3];
  logic [2:0]  clr_cmd_rdy;
  logic [2:0]  clr_rx_rdy;
  logic [2:0]  cmd_rdy;
  logic [2:0]  busy;
  logic [2:0]  timeout_err;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [7:0]  cmd_c;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q [$];

  uart_cmd_sequencer #(.CMD_BYTES(2), .TIMEOUT_CYC(65535)) dut_a (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy[0]), .rx_data(rx_data[0]),
    .clr_rx_rdy(clr_rx_rdy[0]), .cmd(cmd_a), .cmd_rdy(cmd_rdy[0]),
    .clr_cmd_rdy(clr_cmd_rdy[0]), .busy(busy[0]), .timeout_err(timeout_err[0]));

  uart_cmd_sequencer #(.CMD_BYTES(2), .TIMEOUT_CYC(50)) dut_b (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy[1]), .rx_data(rx_data[1]),
    .clr_rx_rdy(clr_rx_rdy[1]), .cmd(cmd_b), .cmd_rdy(cmd_rdy[1]),
    .clr_cmd_rdy(clr_cmd_rdy[1]), .busy(busy[1]), .timeout_err(timeout_err[1]));

  uart_cmd_sequencer #(.CMD_BYTES(1), .TIMEOUT_CYC(50)) dut_c (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy[2]), .rx_data(rx_data[2]),
    .clr_rx_rdy(clr_rx_rdy[2]), .cmd(cmd_c), .cmd_rdy(cmd_rdy[2]),
    .clr_cmd_rdy(clr_cmd_rdy[2]), .busy(busy[2]), .timeout_err(timeout_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_cmd(int s);
    case (s)
      0:       return cmd_a;
      1:       return cmd_b;
      default: return {8'h00, cmd_c};
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller must be aligned just after a posedge; returns just after the accepting edge.
  task automatic send_byte(int s, logic [7:0] b);
    logic got;
    got = 1'b0;
    rx_rdy[s]  = 1'b1;
    rx_data[s] = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = clr_rx_rdy[s];
      @(posedge clk);
      #1;
    end
    rx_rdy[s] = 1'b0;
    chk("byte_accept", 32'(got), 32'd1);
  endtask

  // Expects cmd_rdy in the cycle right after the last-byte accept edge.
  task automatic expect_cmd(int s, string tag);
    logic [15:0] e;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(cmd_rdy[s]), 32'd1);
    chk({tag, "_sb_size"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_cmd"}, 32'(get_cmd(s)), 32'(e));
    end
  endtask

  task automatic clear_cmd(int s);
    @(posedge clk);
    #1;
    clr_cmd_rdy[s] = 1'b1;
    tick();
    clr_cmd_rdy[s] = 1'b0;
    @(negedge clk);
    chk("clr_cmd_drop", 32'(cmd_rdy[s]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic any_clr;
    int   first_k;
    int   pulses;
    logic busy50;
    logic busy51;

    rst         = 1'b1;
    rx_rdy      = 3'b111;
    clr_cmd_rdy = 3'b000;
    for (int i = 0; i < 3; i++) rx_data[i] = 8'h55;

    // Test 1: reset with rx_rdy held high
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_cmd", 32'(cmd_a), 32'd0);
      chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    rx_rdy = 3'b000;
    tick();

    // Test 2: 0xA5, 200 cycles, 0x3C
    exp_q.push_back(16'hA53C);
    send_byte(0, 8'hA5);
    @(negedge clk);
    chk("basic_busy", 32'(busy[0]), 32'd1);
    chk("basic_clr_single", 32'(clr_rx_rdy[0]), 32'd0);
    chk("basic_no_rdy", 32'(cmd_rdy[0]), 32'd0);
    @(posedge clk);
    #1;
    repeat (198) tick();
    chk("basic_busy_gap", 32'(busy[0]), 32'd1);
    send_byte(0, 8'h3C);
    expect_cmd(0, "basic");
    chk("basic_busy_hold", 32'(busy[0]), 32'd0);

    // Test 3: back-pressure in HOLD, then clear/accept ordering
    @(posedge clk);
    #1;
    exp_q.push_back(16'h1122);
    rx_rdy[0]  = 1'b1;
    rx_data[0] = 8'h11;
    any_clr    = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      any_clr |= clr_rx_rdy[0];
    end
    chk("bp_no_clr", 32'(any_clr), 32'd0);
    chk("bp_cmd_stable", 32'(cmd_a), 32'hA53C);
    @(posedge clk);
    #1;
    clr_cmd_rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_clear_first", 32'(clr_rx_rdy[0]), 32'd0);
    @(posedge clk);
    #1;
    clr_cmd_rdy[0] = 1'b0;
    @(negedge clk);
    chk("bp_rdy_drop", 32'(cmd_rdy[0]), 32'd0);
    chk("bp_accept_next", 32'(clr_rx_rdy[0]), 32'd1);
    chk("bp_cmd_kept", 32'(cmd_a), 32'hA53C);
    @(posedge clk);
    #1;
    rx_rdy[0] = 1'b0;
    @(negedge clk);
    chk("bp_busy", 32'(busy[0]), 32'd1);
    chk("bp_msb_shift", 32'(cmd_a[7:0]), 32'h11);
    @(posedge clk);
    #1;
    send_byte(0, 8'h22);
    expect_cmd(0, "bp");
    clear_cmd(0);

    // Test 4: timeout after 50 idle cycles
    send_byte(1, 8'h12);
    first_k = 0;
    pulses  = 0;
    busy50  = 1'b0;
    busy51  = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (timeout_err[1]) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
      if (k == 50) busy50 = busy[1];
      if (k == 51) busy51 = busy[1];
    end
    chk("to_first_cycle", 32'(first_k), 32'd51);
    chk("to_pulse_width", 32'(pulses), 32'd1);
    chk("to_busy_before", 32'(busy50), 32'd1);
    chk("to_busy_after", 32'(busy51), 32'd0);
    @(posedge clk);
    #1;
    chk("to_cmd_rdy", 32'(cmd_rdy[1]), 32'd0);
    exp_q.push_back(16'h3456);
    send_byte(1, 8'h34);
    send_byte(1, 8'h56);
    expect_cmd(1, "to_recover");
    clear_cmd(1);

    // Test 5: second byte lands on the 50th idle cycle
    exp_q.push_back(16'hABCD);
    send_byte(1, 8'hAB);
    repeat (49) tick();
    send_byte(1, 8'hCD);
    expect_cmd(1, "race");
    chk("race_no_err", 32'(timeout_err[1]), 32'd0);
    clear_cmd(1);

    // Test 6: reset mid-command, then CMD_BYTES=1
    send_byte(0, 8'h77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy[0]), 32'd0);
    chk("rstmid_cmd", 32'(cmd_a), 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back(16'h0102);
    send_byte(0, 8'h01);
    send_byte(0, 8'h02);
    expect_cmd(0, "rstmid");
    clear_cmd(0);

    exp_q.push_back(16'h0001);
    send_byte(2, 8'h01);
    expect_cmd(2, "one_byte_a");
    chk("one_byte_busy", 32'(busy[2]), 32'd0);
    clear_cmd(2);
    exp_q.push_back(16'h0002);
    send_byte(2, 8'h02);
    expect_cmd(2, "one_byte_b");
    clear_cmd(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
